// File: rtl/idu_decode_queue.sv
// Decode stage: decodes each accepted RV32/RV64 instruction and queues the bundle in a DEPTH-entry FIFO.
// Optional IDU_PERF_CNT_EN adds perf_decoded/perf_stall event counters.
module idu_decode_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_inst,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [6:0]      out_opcode,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_imm_type,
  output logic            out_rd_wen,
  output logic            out_illegal
`ifdef IDU_PERF_CNT_EN
  ,
  output logic [63:0]     perf_decoded,
  output logic [63:0]     perf_stall
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_type_e;

  imm_type_e   dec_type;
  logic        dec_ill;
  logic        dec_wr_rd;
  logic        dec_wen;
  logic [31:0] dec_imm32;
  logic [XLEN-1:0] dec_imm;

  always_comb begin
    dec_type  = IMM_NONE;
    dec_wr_rd = 1'b0;
    dec_ill   = 1'b0;
    case (in_inst[6:0])
      7'b0110111, 7'b0010111: begin dec_type = IMM_U; dec_wr_rd = 1'b1; end
      7'b1101111:             begin dec_type = IMM_J; dec_wr_rd = 1'b1; end
      7'b1100111, 7'b0000011,
      7'b0010011:             begin dec_type = IMM_I; dec_wr_rd = 1'b1; end
      7'b1110011:             dec_type = IMM_I;
      7'b0100011:             dec_type = IMM_S;
      7'b1100011:             dec_type = IMM_B;
      7'b0110011:             dec_wr_rd = 1'b1;
      7'b0011011: begin
        if (XLEN == 64) begin dec_type = IMM_I; dec_wr_rd = 1'b1; end
        else dec_ill = 1'b1;
      end
      7'b0111011: begin
        if (XLEN == 64) dec_wr_rd = 1'b1;
        else dec_ill = 1'b1;
      end
      default: dec_ill = 1'b1;
    endcase
    if (in_inst[1:0] != 2'b11) dec_ill = 1'b1;
    if (dec_ill) begin
      dec_type  = IMM_NONE;
      dec_wr_rd = 1'b0;
    end

    // Every format fits a 32-bit sign-extended value; widening to XLEN re-extends bit 31.
    case (dec_type)
      IMM_I:   dec_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
      IMM_S:   dec_imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      IMM_B:   dec_imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                            in_inst[11:8], 1'b0};
      IMM_U:   dec_imm32 = {in_inst[31:12], 12'b0};
      IMM_J:   dec_imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                            in_inst[30:21], 1'b0};
      default: dec_imm32 = '0;
    endcase
    dec_imm = XLEN'(signed'(dec_imm32));
    dec_wen = dec_wr_rd && (in_inst[11:7] != 5'd0);
  end

  logic [XLEN-1:0] mem_pc   [DEPTH];
  logic [31:0]     mem_inst [DEPTH];
  logic [XLEN-1:0] mem_imm  [DEPTH];
  logic [2:0]      mem_type [DEPTH];
  logic            mem_wen  [DEPTH];
  logic            mem_ill  [DEPTH];

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop;

  assign in_ready  = (count != FULL_CNT);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_pc[i]   <= '0;
        mem_inst[i] <= '0;
        mem_imm[i]  <= '0;
        mem_type[i] <= '0;
        mem_wen[i]  <= 1'b0;
        mem_ill[i]  <= 1'b0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem_pc[wr_ptr]   <= in_pc;
        mem_inst[wr_ptr] <= in_inst;
        mem_imm[wr_ptr]  <= dec_imm;
        mem_type[wr_ptr] <= dec_type;
        mem_wen[wr_ptr]  <= dec_wen;
        mem_ill[wr_ptr]  <= dec_ill;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  assign out_pc       = mem_pc[rd_ptr];
  assign out_inst     = mem_inst[rd_ptr];
  assign out_imm      = mem_imm[rd_ptr];
  assign out_imm_type = mem_type[rd_ptr];
  assign out_rd_wen   = mem_wen[rd_ptr];
  assign out_illegal  = mem_ill[rd_ptr];
  assign out_rd       = out_inst[11:7];
  assign out_rs1      = out_inst[19:15];
  assign out_rs2      = out_inst[24:20];
  assign out_funct3   = out_inst[14:12];
  assign out_funct7   = out_inst[31:25];
  assign out_opcode   = out_inst[6:0];

`ifdef IDU_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_decoded <= '0;
      perf_stall   <= '0;
    end else begin
      if (push) perf_decoded <= perf_decoded + 64'd1;
      if (in_valid && !in_ready) perf_stall <= perf_stall + 64'd1;
    end
  end
`endif

endmodule
